// File: rtl/mul_err_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_err_scan_ctrl_if
// Purpose  : Bundles the control handshake, the operand/product link to the
//            multiplier under test and the result bus of mul_err_scan_ctrl.
// Ports    : master modport = scan controller side
//              in : start, mode, num_samples, mul_p
//              out: mul_a, mul_b, busy, done, err_count, sum_abs_ed, max_ed,
//                   worst_a, worst_b (+ sum_ed when SIGNED_ED_EN is defined)
//            slave modport  = host / multiplier side (directions mirrored)
// Options  : SIGNED_ED_EN adds the signed error-sum result sum_ed.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_err_scan_ctrl_if #(
  parameter int WIDTH    = 8,
  parameter int SAMPLE_W = 17
);
  logic                          start;
  logic                          mode;
  logic [SAMPLE_W-1:0]           num_samples;
  logic [WIDTH-1:0]              mul_a;
  logic [WIDTH-1:0]              mul_b;
  logic [2*WIDTH-1:0]            mul_p;
  logic                          busy;
  logic                          done;
  logic [SAMPLE_W-1:0]           err_count;
  logic [2*WIDTH+SAMPLE_W-1:0]   sum_abs_ed;
  logic [2*WIDTH-1:0]            max_ed;
  logic [WIDTH-1:0]              worst_a;
  logic [WIDTH-1:0]              worst_b;
`ifdef SIGNED_ED_EN
  logic signed [2*WIDTH+SAMPLE_W:0] sum_ed;

  modport master (
    input  start, mode, num_samples, mul_p,
    output mul_a, mul_b, busy, done, err_count, sum_abs_ed, max_ed,
           worst_a, worst_b, sum_ed
  );

  modport slave (
    output start, mode, num_samples, mul_p,
    input  mul_a, mul_b, busy, done, err_count, sum_abs_ed, max_ed,
           worst_a, worst_b, sum_ed
  );
`else
  modport master (
    input  start, mode, num_samples, mul_p,
    output mul_a, mul_b, busy, done, err_count, sum_abs_ed, max_ed,
           worst_a, worst_b
  );

  modport slave (
    output start, mode, num_samples, mul_p,
    input  mul_a, mul_b, busy, done, err_count, sum_abs_ed, max_ed,
           worst_a, worst_b
  );
`endif
endinterface
`default_nettype wire

// File: rtl/mul_err_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_err_scan_ctrl
// Purpose  : Error-characterisation sequencer for an external combinational
//            approximate multiplier. Generates operand pairs (exhaustive sweep
//            or Galois-LFSR samples), waits a settle time, samples the product
//            and accumulates error count, sum of |error|, maximum |error| and
//            the operands that first produced that maximum.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mul_err_scan_ctrl_if.master (start/mode/num_samples in,
//                     mul_a/mul_b out, mul_p in, busy/done and results out)
// Options  : SIGNED_ED_EN - adds signed accumulator sum_ed of (exact - mul_p).
// Revision : 1.0 - initial release
// ============================================================================
module mul_err_scan_ctrl #(
  parameter int                 WIDTH         = 8,
  parameter int                 SETTLE_CYCLES = 3,
  parameter int                 SAMPLE_W      = 17,
  parameter logic [2*WIDTH-1:0] LFSR_SEED     = 16'hACE1,
  parameter logic [2*WIDTH-1:0] LFSR_TAPS     = 16'hB400
) (
  input  logic                clk,
  input  logic                rst_n,
  mul_err_scan_ctrl_if.master bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int SUM_W = PW + SAMPLE_W;
  // Settle counter counts down from SETTLE_CYCLES-1 to 0.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]    SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  // Number of operand pairs in an exhaustive sweep (2^(2*WIDTH)).
  localparam logic [SAMPLE_W-1:0] EXH_COUNT   = SAMPLE_W'(1) << PW;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q,      state_d;
  logic                mode_q,       mode_d;
  logic [SAMPLE_W-1:0] num_q,        num_d;
  logic [SAMPLE_W-1:0] cnt_q,        cnt_d;
  logic [PW-1:0]       lfsr_q,       lfsr_d;
  logic [SET_W-1:0]    settle_q,     settle_d;
  logic [WIDTH-1:0]    mul_a_q,      mul_a_d;
  logic [WIDTH-1:0]    mul_b_q,      mul_b_d;
  logic                busy_q,       busy_d;
  logic                done_q,       done_d;
  logic [SAMPLE_W-1:0] err_count_q,  err_count_d;
  logic [SUM_W-1:0]    sum_abs_ed_q, sum_abs_ed_d;
  logic [PW-1:0]       max_ed_q,     max_ed_d;
  logic [WIDTH-1:0]    worst_a_q,    worst_a_d;
  logic [WIDTH-1:0]    worst_b_q,    worst_b_d;
`ifdef SIGNED_ED_EN
  logic signed [SUM_W:0] sum_ed_q,   sum_ed_d;
  logic signed [PW:0]    ed_signed;
`endif

  // Datapath helpers
  logic [PW-1:0]       exact;
  logic [PW-1:0]       abs_ed;
  logic [SAMPLE_W-1:0] cnt_inc;
  logic                last_sample;
  logic [PW-1:0]       lfsr_step;

  assign exact   = {{WIDTH{1'b0}}, mul_a_q} * {{WIDTH{1'b0}}, mul_b_q};
  // Subtract in the direction that cannot underflow to get |exact - mul_p|.
  assign abs_ed  = (exact >= bus.mul_p) ? (exact - bus.mul_p) : (bus.mul_p - exact);
  assign cnt_inc = cnt_q + SAMPLE_W'(1);
  assign last_sample = mode_q ? (cnt_inc == num_q) : (cnt_inc == EXH_COUNT);
  // Galois right-shift: feedback applied when the bit shifted out is 1.
  assign lfsr_step = {1'b0, lfsr_q[PW-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : {PW{1'b0}});
`ifdef SIGNED_ED_EN
  assign ed_signed = $signed({1'b0, exact}) - $signed({1'b0, bus.mul_p});
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    num_d        = num_q;
    cnt_d        = cnt_q;
    lfsr_d       = lfsr_q;
    settle_d     = settle_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_count_d  = err_count_q;
    sum_abs_ed_d = sum_abs_ed_q;
    max_ed_d     = max_ed_q;
    worst_a_d    = worst_a_q;
    worst_b_d    = worst_b_q;
`ifdef SIGNED_ED_EN
    sum_ed_d     = sum_ed_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d       = bus.mode;
          num_d        = bus.num_samples;
          cnt_d        = '0;
          lfsr_d       = LFSR_SEED;
          err_count_d  = '0;
          sum_abs_ed_d = '0;
          max_ed_d     = '0;
          worst_a_d    = '0;
          worst_b_d    = '0;
`ifdef SIGNED_ED_EN
          sum_ed_d     = '0;
`endif
          // An empty LFSR scan completes immediately without asserting busy.
          if (bus.mode && (bus.num_samples == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_APPLY;
            busy_d  = 1'b1;
          end
        end
      end

      S_APPLY: begin
        // Exhaustive: counter high byte / low byte, so b advances fastest.
        if (mode_q) begin
          mul_a_d = lfsr_q[PW-1:WIDTH];
          mul_b_d = lfsr_q[WIDTH-1:0];
        end else begin
          mul_a_d = cnt_q[PW-1:WIDTH];
          mul_b_d = cnt_q[WIDTH-1:0];
        end
        settle_d = SETTLE_LOAD;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (settle_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      S_SAMPLE: begin
        if (abs_ed != '0) begin
          err_count_d = err_count_q + SAMPLE_W'(1);
        end
        sum_abs_ed_d = sum_abs_ed_q + {{SAMPLE_W{1'b0}}, abs_ed};
        // Strict compare keeps the first pair that reached the maximum.
        if (abs_ed > max_ed_q) begin
          max_ed_d  = abs_ed;
          worst_a_d = mul_a_q;
          worst_b_d = mul_b_q;
        end
`ifdef SIGNED_ED_EN
        sum_ed_d = sum_ed_q + {{SAMPLE_W{ed_signed[PW]}}, ed_signed};
`endif
        cnt_d  = cnt_inc;
        lfsr_d = lfsr_step;
        if (last_sample) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_APPLY;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      num_q        <= '0;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      settle_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_count_q  <= '0;
      sum_abs_ed_q <= '0;
      max_ed_q     <= '0;
      worst_a_q    <= '0;
      worst_b_q    <= '0;
`ifdef SIGNED_ED_EN
      sum_ed_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      settle_q     <= settle_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_count_q  <= err_count_d;
      sum_abs_ed_q <= sum_abs_ed_d;
      max_ed_q     <= max_ed_d;
      worst_a_q    <= worst_a_d;
      worst_b_q    <= worst_b_d;
`ifdef SIGNED_ED_EN
      sum_ed_q     <= sum_ed_d;
`endif
    end
  end

  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err_count  = err_count_q;
  assign bus.sum_abs_ed = sum_abs_ed_q;
  assign bus.max_ed     = max_ed_q;
  assign bus.worst_a    = worst_a_q;
  assign bus.worst_b    = worst_b_q;
`ifdef SIGNED_ED_EN
  assign bus.sum_ed     = sum_ed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_err_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mul_err_scan_ctrl
// Purpose  : Directed self-checking bench. An 8-bit instance covers LFSR mode,
//            empty scans, start-while-busy and asynchronous reset; a 4-bit
//            instance keeps exhaustive sweeps short (256 pairs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_err_scan_ctrl;

  localparam int S = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   stub_sel = 0;   // 0: exact, 1: exact & ~1, 2: zero, 3: exact + 1
  int   n_checks = 0;
  int   n_errors = 0;
  int   done8_pulses = 0;

  always #5 clk = ~clk;

  mul_err_scan_ctrl_if #(.WIDTH(8), .SAMPLE_W(17)) bus8 ();
  mul_err_scan_ctrl_if #(.WIDTH(4), .SAMPLE_W(9))  bus4 ();

  mul_err_scan_ctrl #(
    .WIDTH(8), .SETTLE_CYCLES(S), .SAMPLE_W(17),
    .LFSR_SEED(16'hACE1), .LFSR_TAPS(16'hB400)
  ) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  mul_err_scan_ctrl #(
    .WIDTH(4), .SETTLE_CYCLES(S), .SAMPLE_W(9),
    .LFSR_SEED(8'hE1), .LFSR_TAPS(8'hB8)
  ) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  function automatic logic [15:0] stub8(input logic [7:0] a, input logic [7:0] b, input int sel);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (sel)
      1:       p = p & 16'hFFFE;
      2:       p = 16'h0000;
      3:       p = p + 16'd1;
      default: ;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] stub4(input logic [3:0] a, input logic [3:0] b, input int sel);
    logic [7:0] p;
    p = 8'(a) * 8'(b);
    case (sel)
      1:       p = p & 8'hFE;
      2:       p = 8'h00;
      3:       p = p + 8'd1;
      default: ;
    endcase
    return p;
  endfunction

  always_comb bus8.mul_p = stub8(bus8.mul_a, bus8.mul_b, stub_sel);
  always_comb bus4.mul_p = stub4(bus4.mul_a, bus4.mul_b, stub_sel);

  always @(posedge clk) if (bus8.done) done8_pulses <= done8_pulses + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Returns at the first negedge after the start-accept edge (cycle index 1).
  task automatic start8(input logic m, input logic [16:0] n);
    @(negedge clk);
    bus8.start = 1'b1; bus8.mode = m; bus8.num_samples = n;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic start4(input logic m);
    @(negedge clk);
    bus4.start = 1'b1; bus4.mode = m; bus4.num_samples = '0;
    @(posedge clk);
    #1 bus4.start = 1'b0;
    @(negedge clk);
  endtask

  // n0 = cycle index of the current negedge relative to the accept edge.
  task automatic wait_done8(input string tag, input int exp_cyc, input int n0);
    int n;
    n = n0;
    while (!bus8.done && n < exp_cyc + 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n), 64'(exp_cyc));
  endtask

  task automatic wait_done4(input string tag, input int exp_cyc);
    int n;
    n = 1;
    while (!bus4.done && n < exp_cyc + 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n), 64'(exp_cyc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    bus8.start = 1'b0; bus8.mode = 1'b0; bus8.num_samples = '0;
    bus4.start = 1'b0; bus4.mode = 1'b0; bus4.num_samples = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",    64'(bus8.busy),       64'd0);
    check("rst_done",    64'(bus8.done),       64'd0);
    check("rst_err",     64'(bus8.err_count),  64'd0);
    check("rst_sum",     64'(bus8.sum_abs_ed), 64'd0);
    check("rst_max",     64'(bus8.max_ed),     64'd0);
    check("rst_mul_a",   64'(bus8.mul_a),      64'd0);
    check("rst_worst_b", 64'(bus8.worst_b),    64'd0);
    rst_n = 1'b1;

    // Exhaustive, exact stub: 256 pairs * (S+2) + 1
    stub_sel = 0;
    start4(1'b0);
    check("ex_busy", 64'(bus4.busy), 64'd1);
    wait_done4("ex_exact_lat", 256 * (S + 2) + 1);
    check("ex_exact_busy_at_done", 64'(bus4.busy),      64'd0);
    check("ex_exact_err",     64'(bus4.err_count),  64'd0);
    check("ex_exact_sum",     64'(bus4.sum_abs_ed), 64'd0);
    check("ex_exact_max",     64'(bus4.max_ed),     64'd0);
    check("ex_exact_worst_a", 64'(bus4.worst_a),    64'd0);
    check("ex_exact_worst_b", 64'(bus4.worst_b),    64'd0);
    check("ex_last_a",        64'(bus4.mul_a),      64'd15);
    check("ex_last_b",        64'(bus4.mul_b),      64'd15);

    // Exhaustive, LSB cleared: errors only when a and b are both odd (8*8)
    stub_sel = 1;
    start4(1'b0);
    wait_done4("ex_lsb_lat", 256 * (S + 2) + 1);
    check("ex_lsb_err",     64'(bus4.err_count),  64'd64);
    check("ex_lsb_sum",     64'(bus4.sum_abs_ed), 64'd64);
    check("ex_lsb_max",     64'(bus4.max_ed),     64'd1);
    check("ex_lsb_worst_a", 64'(bus4.worst_a),    64'd1);
    check("ex_lsb_worst_b", 64'(bus4.worst_b),    64'd1);

`ifdef SIGNED_ED_EN
    // exact - (exact+1) = -1 on every pair
    stub_sel = 3;
    start4(1'b0);
    wait_done4("ex_p1_lat", 256 * (S + 2) + 1);
    check("ex_p1_err",     64'(bus4.err_count),  64'd256);
    check("ex_p1_sum",     64'(bus4.sum_abs_ed), 64'd256);
    check("ex_p1_sum_ed",  64'(longint'(bus4.sum_ed)), 64'(-64'sd256));
    check("ex_p1_max",     64'(bus4.max_ed),     64'd1);
    check("ex_p1_worst_a", 64'(bus4.worst_a),    64'd0);
    check("ex_p1_worst_b", 64'(bus4.worst_b),    64'd0);
`endif

    // LFSR, one sample, zero product: 0xAC*0xE1 = 38700
    stub_sel = 2;
    start8(1'b1, 17'd1);
    @(negedge clk);
    check("lfsr1_wait_a",  64'(bus8.mul_a), 64'hAC);
    check("lfsr1_wait_b",  64'(bus8.mul_b), 64'hE1);
    check("lfsr1_busy",    64'(bus8.busy),  64'd1);
    wait_done8("lfsr1_lat", 1 * (S + 2) + 1, 2);
    check("lfsr1_err",     64'(bus8.err_count),  64'd1);
    check("lfsr1_sum",     64'(bus8.sum_abs_ed), 64'd38700);
    check("lfsr1_max",     64'(bus8.max_ed),     64'd38700);
    check("lfsr1_worst_a", 64'(bus8.worst_a),    64'hAC);
    check("lfsr1_worst_b", 64'(bus8.worst_b),    64'hE1);

    // Empty LFSR scan: done right away, busy never set, results cleared
    start8(1'b1, 17'd0);
    check("empty_done", 64'(bus8.done), 64'd1);
    check("empty_busy", 64'(bus8.busy), 64'd0);
    wait_done8("empty_lat", 1, 1);
    check("empty_err", 64'(bus8.err_count),  64'd0);
    check("empty_sum", 64'(bus8.sum_abs_ed), 64'd0);
    check("empty_max", 64'(bus8.max_ed),     64'd0);
    @(negedge clk);
    check("empty_done_pulse", 64'(bus8.done), 64'd0);
    check("empty_busy_after", 64'(bus8.busy), 64'd0);

    // Three LFSR samples (AC*E1=38700, E2*70=25312, 71*38=6328),
    // with a start pulse while busy that must be ignored.
    start8(1'b1, 17'd3);
    repeat (3) @(negedge clk);
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("lfsr3_lat", 3 * (S + 2) + 1, 5);
    check("lfsr3_err",     64'(bus8.err_count),  64'd3);
    check("lfsr3_sum",     64'(bus8.sum_abs_ed), 64'd70340);
    check("lfsr3_max",     64'(bus8.max_ed),     64'd38700);
    check("lfsr3_worst_a", 64'(bus8.worst_a),    64'hAC);
    check("lfsr3_worst_b", 64'(bus8.worst_b),    64'hE1);

    // Reset in the middle of a long scan (around sample 1000)
    start8(1'b1, 17'd2000);
    repeat (1000 * (S + 2)) @(negedge clk);
    check("mid_busy_before", 64'(bus8.busy), 64'd1);
    snap = done8_pulses;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",    64'(bus8.busy),       64'd0);
    check("arst_err",     64'(bus8.err_count),  64'd0);
    check("arst_sum",     64'(bus8.sum_abs_ed), 64'd0);
    check("arst_max",     64'(bus8.max_ed),     64'd0);
    check("arst_worst_a", 64'(bus8.worst_a),    64'd0);
    check("arst_mul_a",   64'(bus8.mul_a),      64'd0);
    check("arst_mul_b",   64'(bus8.mul_b),      64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_no_done", 64'(done8_pulses), 64'(snap));
    check("arst_idle",    64'(bus8.busy),    64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_err_scan_ctrl.md
Name: mul_err_scan_ctrl

Overview:
- Sequencer for on-chip error characterisation of the 8-bit approximate multipliers.
- Generates operand pairs, exhaustive or LFSR-pseudorandom, and drives them into an external combinational multiplier under test.
- Waits a programmable settle time, then compares the sampled product against the exact product.
- Accumulates error count, sum of absolute error distance, maximum error distance and the worst-case operands; start/done handshake.

Parameters:
- WIDTH, 8, operand width; product width is 2*WIDTH.
- SETTLE_CYCLES, 3, wait cycles between operand apply and product sample; minimum 1.
- SAMPLE_W, 17, width of the sample counter and err_count (2*WIDTH+1).
- LFSR_SEED, 16'hACE1, LFSR reset/start value; must be nonzero.
- LFSR_TAPS, 16'hB400, Galois LFSR feedback mask, 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin scan; sampled only in IDLE.
- mode  in  1  0 = exhaustive sweep, 1 = LFSR sampling; sampled with start.
- num_samples  in  SAMPLE_W  sample count in LFSR mode; ignored in exhaustive mode.
- mul_a  out  WIDTH  operand A to the multiplier under test.
- mul_b  out  WIDTH  operand B to the multiplier under test.
- mul_p  in  2*WIDTH  approximate product from the multiplier under test.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse; scan complete.
- err_count  out  SAMPLE_W  samples with mul_p != exact.
- sum_abs_ed  out  2*WIDTH+SAMPLE_W  sum of |exact - mul_p|.
- max_ed  out  2*WIDTH  largest |exact - mul_p|.
- worst_a  out  WIDTH  operand A of the first sample reaching max_ed.
- worst_b  out  WIDTH  operand B of the first sample reaching max_ed.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0 (mul_a, mul_b, busy, done, err_count, sum_abs_ed, max_ed, worst_a, worst_b).
  - LFSR=LFSR_SEED; sample counter=0.
  - Reset mid-scan aborts immediately with no done pulse.
- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 latches mode and num_samples.
  - Clears all accumulators, worst_*, counter; loads LFSR_SEED.
  - If mode=1 and num_samples=0, go to DONE; otherwise go to APPLY.
- APPLY (1 cycle): mul_a/mul_b are registered from the generator. Exhaustive: a=hi byte and b=lo byte of the counter. LFSR: a=lfsr[15:8], b=lfsr[7:0]. Load the settle counter.
- WAIT: SETTLE_CYCLES cycles; operands held stable.
- SAMPLE (1 cycle):
  - exact = mul_a*mul_b, full 2*WIDTH bits, unsigned; ed = |exact - mul_p|.
  - If ed != 0: err_count += 1.
  - sum_abs_ed += ed; no saturation, widths are sized for the 65536-sample worst case.
  - If ed > max_ed (strict): max_ed=ed, worst_a=mul_a, worst_b=mul_b. Ties keep the first occurrence.
  - Counter += 1; LFSR advances once (Galois: shift right, XOR LFSR_TAPS when the shifted-out bit is 1).
  - If last sample, go to DONE; else go to APPLY.
  - Last sample: exhaustive, counter reaches 2^(2*WIDTH); LFSR, counter reaches num_samples.
- Exhaustive order: b increments fastest; first pair (0,0), last pair (255,255), 65536 samples.
- DONE (1 cycle): done=1, busy=0, go to IDLE.
- Results hold until the next accepted start.
- Timing:
  - Per-sample cost is SETTLE_CYCLES+2 cycles.
  - done is high N*(SETTLE_CYCLES+2)+1 cycles after the start-accept edge.
  - For num_samples=0, done is high 1 cycle after the start-accept edge.
- start while busy: ignored. start held high across DONE: a new scan begins on the next IDLE cycle.
- mul_a/mul_b keep their last value after the scan.

Optional Feature:
- Macro SIGNED_ED_EN.
- Defined:
  - Adds output sum_ed, signed, width 2*WIDTH+SAMPLE_W+1.
  - Accumulates exact - mul_p each SAMPLE; cleared at start and at reset.
- Undefined: port and logic are absent; all other behaviour is unchanged.

Test Plan:
- Stub mul_p = a*b, exhaustive, SETTLE_CYCLES=3 -> err_count=0, sum_abs_ed=0, max_ed=0, worst_a/worst_b=0; done exactly 327681 cycles after start.
- Stub mul_p = (a*b) & 16'hFFFE, exhaustive -> err_count=16384, sum_abs_ed=16384, max_ed=1, worst_a=1, worst_b=1.
- Stub mul_p = 0, LFSR mode, num_samples=1 -> mul_a=8'hAC, mul_b=8'hE1 during WAIT; err_count=1, sum_abs_ed=38700, max_ed=38700, worst_a=8'hAC, worst_b=8'hE1.
- LFSR mode, num_samples=0 -> busy never set; done pulses 1 cycle after start; all results 0.
- rst_n pulled low mid-scan (sample 1000) -> all outputs 0 asynchronously, no done. start pulsed while busy in a second run -> ignored, counts unaffected.
- SIGNED_ED_EN defined, stub mul_p = a*b+1, exhaustive -> err_count=65536, sum_abs_ed=65536, sum_ed=-65536, max_ed=1, worst_a=0, worst_b=0.
